// File: rtl/valet_desk.sv
// Front-desk sequencer for the cam_lot tag store: arbitrates park/retrieve
// requests, probes the CAM, issues at most one strobe and returns a coded response.
module valet_desk #(
  parameter int TAG_WIDTH = 16,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       park_valid,
  output logic                       park_ready,
  input  logic [TAG_WIDTH-1:0]       park_tag,
  input  logic                       ret_valid,
  output logic                       ret_ready,
  input  logic [TAG_WIDTH-1:0]       ret_tag,
  output logic                       cam_write_en,
  output logic                       cam_read_en,
  output logic [TAG_WIDTH-1:0]       cam_tag,
  input  logic [TAG_WIDTH-1:0]       cam_tag_out,
  input  logic                       cam_match_found,
  input  logic [$clog2(DEPTH)-1:0]   cam_match_index,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [1:0]                 resp_code,
  output logic [$clog2(DEPTH)-1:0]   resp_index,
  output logic [TAG_WIDTH-1:0]       resp_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  localparam logic [1:0] CODE_OK   = 2'd0;
  localparam logic [1:0] CODE_DUP  = 2'd1;
  localparam logic [1:0] CODE_MISS = 2'd2;
  localparam logic [1:0] CODE_FULL = 2'd3;

  typedef enum logic [1:0] {IDLE, PROBE, ACT, RESP} state_t;

  state_t           state, state_next;
  logic             op_ret;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             ret_pri;
  logic             grant_ret, grant_park, accept;
  logic             lot_full;

  // Round-robin grant: ret_pri says which channel wins the next contention.
  always_comb begin
    grant_ret    = ret_valid && (!park_valid || ret_pri);
    grant_park   = park_valid && !grant_ret;
    park_ready   = (state == IDLE) && grant_park;
    ret_ready    = (state == IDLE) && grant_ret;
    accept       = park_ready || ret_ready;
    lot_full     = (occupancy == OCC_FULL);
    cam_write_en = (state == ACT) && !op_ret && !hit && !lot_full;
    cam_read_en  = (state == ACT) && op_ret && hit;
    resp_valid   = (state == RESP);
    state_next   = state;
    case (state)
      IDLE:    if (accept) state_next = PROBE;
      PROBE:   state_next = ACT;
      ACT:     state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cam_tag    <= '0;
      op_ret     <= 1'b0;
      hit        <= 1'b0;
      idx        <= '0;
      ret_pri    <= 1'b1;
      resp_code  <= CODE_OK;
      resp_index <= '0;
      resp_tag   <= '0;
      occupancy  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cam_tag <= ret_ready ? ret_tag : park_tag;
        op_ret  <= ret_ready;
        ret_pri <= !ret_ready;
      end
      if (state == PROBE) begin
        hit <= cam_match_found;
        idx <= cam_match_index;
      end
      // The response fields are loaded once in ACT and held through RESP.
      if (state == ACT) begin
        resp_tag   <= cam_tag;
        resp_index <= '0;
        if (op_ret) begin
          if (hit) begin
            resp_code  <= CODE_OK;
            resp_index <= idx;
            resp_tag   <= cam_tag_out;
          end else begin
            resp_code <= CODE_MISS;
          end
        end else if (hit) begin
          resp_code  <= CODE_DUP;
          resp_index <= idx;
        end else if (lot_full) begin
          resp_code <= CODE_FULL;
        end else begin
          resp_code <= CODE_OK;
        end
        if (cam_write_en && !lot_full) begin
          occupancy <= occupancy + OCC_W'(1);
        end else if (cam_read_en && occupancy != '0) begin
          occupancy <= occupancy - OCC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_valet_desk.sv
// Bench for valet_desk: a behavioural CAM, a request-level reference model,
// directed literal checks and a randomized phase.
module tb_valet_desk;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        park_valid, park_ready, ret_valid, ret_ready;
  logic [15:0] park_tag, ret_tag;
  logic        cam_write_en, cam_read_en;
  logic [15:0] cam_tag, cam_tag_out;
  logic        cam_match_found;
  logic [2:0]  cam_match_index;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_code;
  logic [2:0]  resp_index;
  logic [15:0] resp_tag;
  logic [3:0]  occupancy;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  valet_desk #(.TAG_WIDTH(16), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .park_valid(park_valid), .park_ready(park_ready), .park_tag(park_tag),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_tag(ret_tag),
    .cam_write_en(cam_write_en), .cam_read_en(cam_read_en), .cam_tag(cam_tag),
    .cam_tag_out(cam_tag_out), .cam_match_found(cam_match_found),
    .cam_match_index(cam_match_index),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code),
    .resp_index(resp_index), .resp_tag(resp_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Stand-in for cam_lot: stores into the lowest free slot, matches lowest slot.
  logic [15:0] lot_tag [D];
  bit          lot_used [D];
  int          cam_free;

  always_comb begin
    cam_match_found = 1'b0;
    cam_match_index = '0;
    cam_tag_out     = '0;
    cam_free        = -1;
    for (int i = D-1; i >= 0; i--) begin
      if (lot_used[i] && lot_tag[i] == cam_tag) begin
        cam_match_found = 1'b1;
        cam_match_index = 3'(i);
        cam_tag_out     = lot_tag[i];
      end
      if (!lot_used[i]) cam_free = i;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) lot_used[i] <= 1'b0;
    end else begin
      if (cam_write_en && cam_free >= 0) begin
        lot_used[cam_free] <= 1'b1;
        lot_tag[cam_free]  <= cam_tag;
      end
      if (cam_read_en && cam_match_found) lot_used[cam_match_index] <= 1'b0;
    end
  end

  // Reference model: one request at a time, phase 0..3 counts cycles after grant.
  int          m_phase, m_occ, m_idx, m_sel;
  bit          m_ret_pri, m_we, m_re;
  logic [15:0] m_tag, m_rtag;
  logic [1:0]  m_code;
  logic [15:0] m_slot [D];
  bit          m_used [D];
  logic        exp_ret_ready, exp_park_ready;
  logic [15:0] mt_req;
  bit          mt_hit;
  int          mt_hidx, mt_free;

  assign exp_ret_ready  = (m_phase == 0) && ret_valid && (!park_valid || m_ret_pri);
  assign exp_park_ready = (m_phase == 0) && park_valid && (!ret_valid || !m_ret_pri);

  always_comb begin
    mt_req  = exp_ret_ready ? ret_tag : park_tag;
    mt_hit  = 1'b0;
    mt_hidx = 0;
    mt_free = -1;
    for (int i = D-1; i >= 0; i--) begin
      if (m_used[i] && m_slot[i] == mt_req) begin
        mt_hit  = 1'b1;
        mt_hidx = i;
      end
      if (!m_used[i]) mt_free = i;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase   <= 0;
      m_ret_pri <= 1'b1;
      m_occ     <= 0;
      m_tag     <= '0;
      m_rtag    <= '0;
      m_code    <= '0;
      m_idx     <= 0;
      m_sel     <= 0;
      m_we      <= 1'b0;
      m_re      <= 1'b0;
      for (int i = 0; i < D; i++) m_used[i] <= 1'b0;
    end else begin
      case (m_phase)
        0: if (exp_ret_ready || exp_park_ready) begin
          m_tag     <= mt_req;
          m_rtag    <= mt_req;
          m_ret_pri <= !exp_ret_ready;
          m_we      <= 1'b0;
          m_re      <= 1'b0;
          m_idx     <= 0;
          m_sel     <= 0;
          if (exp_ret_ready) begin
            if (mt_hit) begin
              m_code <= 2'd0; m_idx <= mt_hidx; m_re <= 1'b1; m_sel <= mt_hidx;
            end else begin
              m_code <= 2'd2;
            end
          end else if (mt_hit) begin
            m_code <= 2'd1; m_idx <= mt_hidx;
          end else if (m_occ == D) begin
            m_code <= 2'd3;
          end else begin
            m_code <= 2'd0; m_we <= 1'b1; m_sel <= mt_free;
          end
          m_phase <= 1;
        end
        1: m_phase <= 2;
        2: begin
          if (m_we) begin
            m_used[m_sel] <= 1'b1;
            m_slot[m_sel] <= m_tag;
            m_occ         <= m_occ + 1;
          end
          if (m_re) begin
            m_used[m_sel] <= 1'b0;
            m_occ         <= m_occ - 1;
          end
          m_phase <= 3;
        end
        default: if (resp_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareCycle();
    checkOutput("park_ready", 32'(park_ready), 32'(exp_park_ready));
    checkOutput("ret_ready", 32'(ret_ready), 32'(exp_ret_ready));
    checkOutput("ready_exclusive", 32'(park_ready && ret_ready), 0);
    checkOutput("cam_write_en", 32'(cam_write_en), 32'(m_phase == 2 && m_we));
    checkOutput("cam_read_en", 32'(cam_read_en), 32'(m_phase == 2 && m_re));
    checkOutput("cam_tag", 32'(cam_tag), 32'(m_tag));
    checkOutput("occupancy", 32'(occupancy), 32'(m_occ));
    checkOutput("resp_valid", 32'(resp_valid), 32'(m_phase == 3));
    if (m_phase == 3) begin
      checkOutput("resp_code", 32'(resp_code), 32'(m_code));
      checkOutput("resp_index", 32'(resp_index), 32'(m_idx));
      checkOutput("resp_tag", 32'(resp_tag), 32'(m_rtag));
    end
  endtask

  task automatic waitGrant(input bit is_ret, output int got);
    got = 0;
    for (int c = 0; c < 12 && got == 0; c++) begin
      @(negedge clk);
      if (is_ret ? ret_ready : park_ready) got = 1;
    end
    checkOutput("request_accepted", 32'(got), 1);
  endtask

  task automatic applyStimulus(input bit is_ret, input logic [15:0] tag, input logic [1:0] ecode,
                               input logic [2:0] eidx, input logic [15:0] etag, input int eocc,
                               input bit ewe, input bit ere);
    int got;
    @(posedge clk); #1;
    if (is_ret) begin ret_valid = 1'b1; ret_tag = tag; end
    else begin park_valid = 1'b1; park_tag = tag; end
    waitGrant(is_ret, got);
    @(posedge clk); #1;
    park_valid = 1'b0;
    ret_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("lit_write_en", 32'(cam_write_en), 32'(ewe));
    checkOutput("lit_read_en", 32'(cam_read_en), 32'(ere));
    @(negedge clk);
    checkOutput("lit_resp_valid", 32'(resp_valid), 1);
    checkOutput("lit_resp_code", 32'(resp_code), 32'(ecode));
    checkOutput("lit_resp_index", 32'(resp_index), 32'(eidx));
    checkOutput("lit_resp_tag", 32'(resp_tag), 32'(etag));
    checkOutput("lit_occupancy", 32'(occupancy), 32'(eocc));
  endtask

  task automatic runTests();
    int got, gr;
    repeat (3) @(negedge clk);
    checkOutput("rst_write_en", 32'(cam_write_en), 0);
    checkOutput("rst_read_en", 32'(cam_read_en), 0);
    checkOutput("rst_cam_tag", 32'(cam_tag), 0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 0);
    checkOutput("rst_resp_code", 32'(resp_code), 0);
    checkOutput("rst_resp_index", 32'(resp_index), 0);
    checkOutput("rst_resp_tag", 32'(resp_tag), 0);
    checkOutput("rst_occupancy", 32'(occupancy), 0);
    @(posedge clk); #1 rst = 1'b1;

    applyStimulus(1'b0, 16'h1234, 2'd0, 3'd0, 16'h1234, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h1234, 2'd1, 3'd0, 16'h1234, 1, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0042, 2'd0, 3'd0, 16'h0042, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 2'd2, 3'd0, 16'hBEEF, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0042, 2'd0, 3'd1, 16'h0042, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0042, 2'd0, 3'd0, 16'h0042, 2, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++)
      applyStimulus(1'b0, 16'(k), 2'd0, 3'd0, 16'(k), 2 + k, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h00FF, 2'd3, 3'd0, 16'h00FF, 8, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 2'd0, 3'd0, 16'h1234, 7, 1'b0, 1'b1);

    // Random traffic over a small tag pool so hits, misses and full all recur.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      park_valid = ($urandom_range(0, 2) != 0);
      ret_valid  = ($urandom_range(0, 2) != 0);
      park_tag   = 16'($urandom_range(0, 11));
      ret_tag    = 16'($urandom_range(0, 11));
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    park_valid = 1'b0;
    ret_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (6) @(posedge clk);

    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    park_valid = 1'b1; park_tag = 16'h0100;
    ret_valid  = 1'b1; ret_tag  = 16'h0100;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      gr  = 0;
      for (int c = 0; c < 12 && got == 0; c++) begin
        @(negedge clk);
        if (park_ready || ret_ready) begin
          got = 1;
          gr  = int'(ret_ready);
        end
      end
      checkOutput("contention_grant_seen", 32'(got), 1);
      checkOutput($sformatf("contention_grant%0d_is_ret", g), 32'(gr), 32'(g % 2 == 0));
      @(posedge clk);
    end
    #1;
    park_valid = 1'b0;
    ret_valid  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("contention_occupancy", 32'(occupancy), 1);

    @(posedge clk); #1;
    park_valid = 1'b1;
    park_tag   = 16'h0777;
    waitGrant(1'b0, got);
    @(posedge clk); #1 park_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_write_before", 32'(cam_write_en), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_write_en", 32'(cam_write_en), 0);
    checkOutput("abort_read_en", 32'(cam_read_en), 0);
    checkOutput("abort_resp_valid", 32'(resp_valid), 0);
    checkOutput("abort_cam_tag", 32'(cam_tag), 0);
    checkOutput("abort_occupancy", 32'(occupancy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 32'(resp_valid), 0);
    end
    checkOutput("abort_occ_after", 32'(occupancy), 0);
    done = 1'b1;
  endtask

  initial begin
    park_valid = 1'b0;
    ret_valid  = 1'b0;
    park_tag   = '0;
    ret_tag    = '0;
    resp_ready = 1'b1;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          compareCycle();
        end
      end
      runTests();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
